// File: rtl/pixel_compositor_if.sv
// Pixel compositor bus: per-pixel layer inputs from the raster source and the
// composited VGA-side outputs. The master drives pixels, the slave composites.
interface pixel_compositor_if #(
    parameter int N_LAYERS = 4,
    parameter int COLOR_W  = 8
);
    logic [9:0]                    pixelx;
    logic [9:0]                    pixely;
    logic [N_LAYERS-1:0]           layer_visible;
    logic [N_LAYERS*3*COLOR_W-1:0] layer_color;
    logic [N_LAYERS-1:0]           blink_mask;
    logic [1:0]                    mode;
    logic [COLOR_W-1:0]            vga_r;
    logic [COLOR_W-1:0]            vga_g;
    logic [COLOR_W-1:0]            vga_b;
    logic                          blank;
    logic                          sync;
    logic [3:0]                    hit_layer;

    modport master (
        output pixelx, pixely, layer_visible, layer_color, blink_mask, mode,
        input  vga_r, vga_g, vga_b, blank, sync, hit_layer
    );

    modport slave (
        input  pixelx, pixely, layer_visible, layer_color, blink_mask, mode,
        output vga_r, vga_g, vga_b, blank, sync, hit_layer
    );
endinterface

// File: rtl/pixel_compositor.sv
// Two-stage layer compositor. Stage 1 resolves blink-masked visibility into the
// top and second layer; stage 2 produces the mode-dependent colour, blanking
// and winning-layer index. A frame counter drives the blink phase.
module pixel_compositor #(
    parameter int                     N_LAYERS     = 4,
    parameter int                     COLOR_W      = 8,
    parameter int                     BLINK_FRAMES = 30,
    parameter logic [3*COLOR_W-1:0]   BG_COLOR     = {8'd165, 8'd196, 8'd212}
) (
    input  logic              clk,
    input  logic              rst,
    pixel_compositor_if.slave px_bus
);
    localparam int CW3   = 3 * COLOR_W;
    // Index and popcount share a 3-bit field placed in the channel MSBs for
    // the debug view; a popcount of 8 wraps to 0 in that field.
    localparam int IDX_W = 3;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Per-channel average with a carry-preserving sum, truncating the LSB.
    function automatic logic [COLOR_W-1:0] avg_chan(input logic [COLOR_W-1:0] a,
                                                    input logic [COLOR_W-1:0] b);
        logic [COLOR_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[COLOR_W:1];
    endfunction

    function automatic logic [CW3-1:0] blend_rgb(input logic [CW3-1:0] a,
                                                 input logic [CW3-1:0] b);
        logic [CW3-1:0] res;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            res[c*COLOR_W +: COLOR_W] = avg_chan(a[c*COLOR_W +: COLOR_W],
                                                 b[c*COLOR_W +: COLOR_W]);
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] popcount(input logic [N_LAYERS-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (v[i]) cnt++;
        end
        return IDX_W'(cnt);
    endfunction

    function automatic logic [COLOR_W-1:0] scale_field(input logic [IDX_W-1:0] v);
        return COLOR_W'(v) << (COLOR_W - IDX_W);
    endfunction

    // ---------------- frame tick / blink phase ----------------
    logic             at_origin;
    logic             frame_tick;
    logic             prev_origin_q;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             blink_phase_q, blink_phase_d;

    assign at_origin  = (px_bus.pixelx == 10'd0) && (px_bus.pixely == 10'd0);
    assign frame_tick = at_origin && !prev_origin_q;

    // Next frame count and blink phase; wrap toggles the phase.
    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_tick) begin
            if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Origin edge detector, frame counter and blink phase. The origin flag
    // resets high so holding (0,0) through reset does not count a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_origin_q <= 1'b1;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            prev_origin_q <= at_origin;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // ---------------- stage 1: visibility and layer pick ----------------
    logic [N_LAYERS-1:0] eff_vis;
    logic                top_vld_d, sec_vld_d;
    logic [IDX_W-1:0]    top_idx_d;
    logic [CW3-1:0]      top_col_d, sec_col_d;

    assign eff_vis = px_bus.layer_visible & ~(px_bus.blink_mask & {N_LAYERS{blink_phase_q}});

    // Lowest set index wins; second is the lowest set index other than the top.
    always_comb begin
        top_vld_d = 1'b0;
        top_idx_d = '0;
        top_col_d = '0;
        sec_vld_d = 1'b0;
        sec_col_d = '0;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (eff_vis[i]) begin
                top_vld_d = 1'b1;
                top_idx_d = IDX_W'(i);
                top_col_d = px_bus.layer_color[i*CW3 +: CW3];
            end
        end
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (eff_vis[i] && (IDX_W'(i) != top_idx_d)) begin
                sec_vld_d = 1'b1;
                sec_col_d = px_bus.layer_color[i*CW3 +: CW3];
            end
        end
    end

    logic                s1_vld_q;
    logic [9:0]          s1_px_q, s1_py_q;
    logic [1:0]          s1_mode_q;
    logic [N_LAYERS-1:0] s1_vis_q;
    logic                s1_top_vld_q, s1_sec_vld_q;
    logic [IDX_W-1:0]    s1_top_idx_q;
    logic [CW3-1:0]      s1_top_col_q, s1_sec_col_q;

    // Stage 1 register; the valid bit keeps reset contents off the screen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q     <= 1'b0;
            s1_px_q      <= '0;
            s1_py_q      <= '0;
            s1_mode_q    <= '0;
            s1_vis_q     <= '0;
            s1_top_vld_q <= 1'b0;
            s1_top_idx_q <= '0;
            s1_top_col_q <= '0;
            s1_sec_vld_q <= 1'b0;
            s1_sec_col_q <= '0;
        end else begin
            s1_vld_q     <= 1'b1;
            s1_px_q      <= px_bus.pixelx;
            s1_py_q      <= px_bus.pixely;
            s1_mode_q    <= px_bus.mode;
            s1_vis_q     <= eff_vis;
            s1_top_vld_q <= top_vld_d;
            s1_top_idx_q <= top_idx_d;
            s1_top_col_q <= top_col_d;
            s1_sec_vld_q <= sec_vld_d;
            s1_sec_col_q <= sec_col_d;
        end
    end

    // ---------------- stage 2: colour, blank, hit ----------------
    logic [CW3-1:0] col_d;
    logic [3:0]     hit_d;
    logic           blank_d;

    // Mode-dependent colour; anything outside the visible area is forced black.
    always_comb begin
        col_d = BG_COLOR;
        hit_d = 4'hF;
        case (s1_mode_q)
            2'b00: begin
                if (s1_top_vld_q) begin
                    col_d = s1_top_col_q;
                    hit_d = 4'(s1_top_idx_q);
                end
            end
            2'b01: begin
                if (s1_top_vld_q) begin
                    col_d = blend_rgb(s1_top_col_q, s1_sec_vld_q ? s1_sec_col_q : BG_COLOR);
                    hit_d = 4'(s1_top_idx_q);
                end
            end
            2'b10: begin
                col_d = BG_COLOR;
            end
            default: begin
                if (s1_top_vld_q) begin
                    col_d = {scale_field(s1_top_idx_q), {COLOR_W{1'b0}},
                             scale_field(popcount(s1_vis_q))};
                    hit_d = 4'(s1_top_idx_q);
                end
            end
        endcase
        blank_d = s1_vld_q && (s1_px_q < 10'd640) && (s1_py_q < 10'd480);
        if (!blank_d) col_d = '0;
    end

    logic [CW3-1:0] s2_col_q;
    logic [3:0]     s2_hit_q;
    logic           s2_blank_q;

    // Stage 2 output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_col_q   <= '0;
            s2_hit_q   <= 4'hF;
            s2_blank_q <= 1'b0;
        end else begin
            s2_col_q   <= col_d;
            s2_hit_q   <= hit_d;
            s2_blank_q <= blank_d;
        end
    end

    assign px_bus.vga_r     = s2_col_q[2*COLOR_W +: COLOR_W];
    assign px_bus.vga_g     = s2_col_q[COLOR_W +: COLOR_W];
    assign px_bus.vga_b     = s2_col_q[0 +: COLOR_W];
    assign px_bus.blank     = s2_blank_q;
    assign px_bus.hit_layer = s2_hit_q;
    assign px_bus.sync      = 1'b1;
endmodule

// File: tb/tb_pixel_compositor.sv
// Testbench for pixel_compositor: table of single-pixel vectors, blink frame
// sequences and reset sequences, all checked through a 2-deep scoreboard.
module tb_pixel_compositor;
    localparam int NL = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pixel_compositor_if #(.N_LAYERS(NL), .COLOR_W(CW)) bus ();

    pixel_compositor #(
        .N_LAYERS    (NL),
        .COLOR_W     (CW),
        .BLINK_FRAMES(2),
        .BG_COLOR    (24'hA5C4D4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .px_bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         chk;
        logic [23:0]  rgb;
        logic         blank;
        logic [3:0]   hit;
        logic [127:0] tag;
    } exp_t;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [3:0]  vis;
        logic [95:0] col;
        logic [1:0]  md;
        logic [23:0] rgb;
        logic        bl;
        logic [3:0]  hit;
    } vec_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic release_rst = 1'b0;

    localparam logic [95:0] COLS  = {24'h202020, 24'h00FF00, 24'hFF0000, 24'h123456};
    localparam logic [95:0] COLSW = {24'h202020, 24'h00FF00, 24'hFF0000, 24'hFFFFFF};
    localparam logic [95:0] BCOL  = {24'h000000, 24'h000000, 24'h405060, 24'h102030};

    task automatic check_out(input exp_t e);
        logic [23:0] got;
        got = {bus.vga_r, bus.vga_g, bus.vga_b};
        total++;
        if (got !== e.rgb || bus.blank !== e.blank || bus.hit_layer !== e.hit || bus.sync !== 1'b1) begin
            bad++;
            $display("FAIL %s: got rgb=%06h blank=%0b hit=%h sync=%0b, want rgb=%06h blank=%0b hit=%h sync=1",
                     e.tag, got, bus.blank, bus.hit_layer, bus.sync, e.rgb, e.blank, e.hit);
        end
    endtask

    // One pixel per clock: retire the expectation from two clocks ago, then drive.
    task automatic step(input logic [9:0] x, input logic [9:0] y, input logic [3:0] vis,
                        input logic [3:0] mask, input logic [95:0] col, input logic [1:0] md,
                        input logic chk, input logic [23:0] rgb, input logic bl,
                        input logic [3:0] hit, input logic [127:0] tag);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            if (e.chk) check_out(e);
        end
        if (release_rst) begin
            rst = 1'b1;
            release_rst = 1'b0;
        end
        bus.pixelx        = x;
        bus.pixely        = y;
        bus.layer_visible = vis;
        bus.blink_mask    = mask;
        bus.layer_color   = col;
        bus.mode          = md;
        e.chk = chk; e.rgb = rgb; e.blank = bl; e.hit = hit; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Blink test pixel: phase 0 shows layer 0, phase 1 masks it and shows layer 1.
    task automatic bpix(input logic [9:0] x, input logic [9:0] y, input logic ph,
                        input logic [127:0] tag);
        step(x, y, 4'b0011, 4'b0001, BCOL, 2'b00, 1'b1,
             ph ? 24'h405060 : 24'h102030, 1'b1, ph ? 4'h1 : 4'h0, tag);
    endtask

    // Frame start held at (0,0) for 'hold' clocks; only the first is a tick.
    task automatic frame(input int hold, input logic pb, input logic pa);
        bpix(10'd0, 10'd0, pb, "tick_pix");
        for (int k = 1; k < hold; k++) bpix(10'd0, 10'd0, pa, "hold_pix");
        bpix(10'd10, 10'd10, pa, "frame_pix");
        bpix(10'd10, 10'd10, pa, "frame_pix");
    endtask

    task automatic assert_reset_and_check(input logic [127:0] tag);
        exp_t e;
        rst = 1'b0;
        #1;
        e.chk = 1'b1; e.rgb = 24'h0; e.blank = 1'b0; e.hit = 4'hF; e.tag = tag;
        check_out(e);
        exp_q.delete();
        // first clock after release still shows the reset-state bubble
        e.tag = "bubble";
        exp_q.push_back(e);
        release_rst = 1'b1;
    endtask

    vec_t tbl[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{10'd10,  10'd10,  4'b0110, COLS,  2'b00, 24'hFF0000, 1'b1, 4'h1};
        tbl[1]  = '{10'd10,  10'd10,  4'b0110, COLS,  2'b01, 24'h7F7F00, 1'b1, 4'h1};
        tbl[2]  = '{10'd10,  10'd10,  4'b1000, COLS,  2'b01, 24'h62727A, 1'b1, 4'h3};
        tbl[3]  = '{10'd700, 10'd10,  4'b0000, COLS,  2'b00, 24'h000000, 1'b0, 4'hF};
        tbl[4]  = '{10'd10,  10'd10,  4'b0000, COLS,  2'b00, 24'hA5C4D4, 1'b1, 4'hF};
        tbl[5]  = '{10'd10,  10'd10,  4'b1100, COLS,  2'b11, 24'h400040, 1'b1, 4'h2};
        tbl[6]  = '{10'd10,  10'd10,  4'b0110, COLS,  2'b10, 24'hA5C4D4, 1'b1, 4'hF};
        tbl[7]  = '{10'd10,  10'd10,  4'b0000, COLS,  2'b11, 24'hA5C4D4, 1'b1, 4'hF};
        tbl[8]  = '{10'd10,  10'd10,  4'b1111, COLS,  2'b00, 24'h123456, 1'b1, 4'h0};
        tbl[9]  = '{10'd10,  10'd10,  4'b1111, COLS,  2'b01, 24'h881A2B, 1'b1, 4'h0};
        tbl[10] = '{10'd10,  10'd10,  4'b0001, COLSW, 2'b01, 24'hD2E1E9, 1'b1, 4'h0};
        tbl[11] = '{10'd10,  10'd10,  4'b1111, COLS,  2'b11, 24'h000080, 1'b1, 4'h0};
        tbl[12] = '{10'd639, 10'd479, 4'b0001, COLS,  2'b00, 24'h123456, 1'b1, 4'h0};
        tbl[13] = '{10'd640, 10'd479, 4'b0001, COLS,  2'b00, 24'h000000, 1'b0, 4'h0};
        tbl[14] = '{10'd639, 10'd480, 4'b0001, COLS,  2'b00, 24'h000000, 1'b0, 4'h0};
        tbl[15] = '{10'd10,  10'd10,  4'b1010, COLS,  2'b01, 24'h8F1010, 1'b1, 4'h1};

        bus.pixelx = 10'd10; bus.pixely = 10'd10; bus.layer_visible = '0;
        bus.blink_mask = '0; bus.layer_color = '0; bus.mode = 2'b00;

        // power-on reset
        #1;
        assert_reset_and_check("reset_init");
        repeat (2) @(posedge clk);

        // single-pixel vectors, one per clock with changing modes
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].x, tbl[i].y, tbl[i].vis, 4'b0000, tbl[i].col, tbl[i].md, 1'b1,
                 tbl[i].rgb, tbl[i].bl, tbl[i].hit, "table");
        end

        // blink: ticks 1..6, phase toggles after every second tick
        frame(5, 1'b0, 1'b0);
        frame(2, 1'b0, 1'b1);
        frame(3, 1'b1, 1'b1);
        frame(1, 1'b1, 1'b0);
        frame(2, 1'b0, 1'b0);
        frame(3, 1'b0, 1'b1);

        // mid-line reset while blink phase is 1
        bpix(10'd20, 10'd5, 1'b1, "pre_reset");
        #2;
        assert_reset_and_check("reset_midline");
        @(posedge clk);

        // (0,0) straight out of reset is not a tick
        bpix(10'd0, 10'd0, 1'b0, "post_rst_org");
        bpix(10'd0, 10'd0, 1'b0, "post_rst_org");
        bpix(10'd0, 10'd0, 1'b0, "post_rst_org");
        bpix(10'd10, 10'd10, 1'b0, "post_rst_pix");
        bpix(10'd0, 10'd0, 1'b0, "tick1_pix");
        bpix(10'd10, 10'd10, 1'b0, "after_tick1");
        bpix(10'd0, 10'd0, 1'b0, "tick2_pix");
        bpix(10'd0, 10'd0, 1'b1, "after_tick2");
        bpix(10'd10, 10'd10, 1'b1, "after_tick2");

        // drain the pipeline
        step(10'd10, 10'd10, 4'b0000, 4'b0000, COLS, 2'b00, 1'b0, 24'h0, 1'b0, 4'h0, "idle");
        step(10'd10, 10'd10, 4'b0000, 4'b0000, COLS, 2'b00, 1'b0, 24'h0, 1'b0, 4'h0, "idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
